// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall controller:
// FSM state encoding, default memory-wait timeout and the load-use hazard rule.
package pipeline_stall_controller_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_t;

   localparam int TIMEOUT_DEFAULT = 256;
   localparam int WAIT_W          = 16;

   // A load into r0 never creates a dependency, so rd==0 is excluded up front.
   function automatic logic load_use_hazard(input logic [4:0] rs,
                                            input logic [4:0] rt,
                                            input logic       uses_rt,
                                            input logic [4:0] rd,
                                            input logic       mem_read);
      return mem_read && (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
   endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush/wait performance counters.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard/stall controller for a 5-stage pipeline: load-use stalls, branch flushes,
// memory-wait freezes with a timeout error state, and saturating event counters.
module pipeline_stall_controller
   import pipeline_stall_controller_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_freeze,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] cnt_lu,
   output logic [CNT_W-1:0] cnt_br,
   output logic [CNT_W-1:0] cnt_mw
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mw;
   logic              lu;
   logic              in_error;

   assign mw       = mem_req && !mem_ready;
   assign lu       = load_use_hazard(id_rs, id_rt, id_uses_rt, ex_rd, ex_mem_read);
   assign in_error = (state == ST_ERROR);

   // wait_cnt holds the number of consecutive mw cycles already seen; the cycle
   // that would make it TIMEOUT moves to ERROR instead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (mw) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end else begin
                  wait_cnt <= '0;
               end
            end
            ST_MEM_WAIT: begin
               if (!mw) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= ST_ERROR;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_ERROR: state <= ST_ERROR;
            default:  state <= ST_RUN;
         endcase
      end
   end

   // NOTE: every output gets a default before the priority chain, so no path
   // through this block can leave a signal unassigned and infer a latch.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_freeze  = 1'b0;
      mem_timeout  = 1'b0;
      if (!rst_n) begin
         pc_write = 1'b1;
      end else if (in_error) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_freeze = 1'b1;
         mem_timeout = 1'b1;
      end else if (mw) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_freeze = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (lu) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_cnt_lu (
      .clk(clk), .rst_n(rst_n), .clear(1'b0),
      .inc(!in_error && !mw && !ex_branch_taken && lu), .count(cnt_lu)
   );

   sat_counter #(.WIDTH(CNT_W)) u_cnt_br (
      .clk(clk), .rst_n(rst_n), .clear(1'b0),
      .inc(!in_error && !mw && ex_branch_taken), .count(cnt_br)
   );

   sat_counter #(.WIDTH(CNT_W)) u_cnt_mw (
      .clk(clk), .rst_n(rst_n), .clear(1'b0),
      .inc(!in_error && mw), .count(cnt_mw)
   );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// cycle-level behavioural model, on a default instance and a TIMEOUT=4/CNT_W=2 one.
module tb_pipeline_stall_controller;

   logic        clk;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

   logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout;
   logic [15:0] cnt_lu, cnt_br, cnt_mw;
   logic        pc_write_s, if_id_write_s, if_id_flush_s, id_ex_bubble_s, pipe_freeze_s, mem_timeout_s;
   logic [1:0]  cnt_lu_s, cnt_br_s, cnt_mw_s;

   logic [5:0]  ctrl, ctrl_s;
   assign ctrl   = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout};
   assign ctrl_s = {pc_write_s, if_id_write_s, if_id_flush_s, id_ex_bubble_s, pipe_freeze_s, mem_timeout_s};

   int checks   = 0;
   int failures = 0;

   pipeline_stall_controller u_dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
      .mem_timeout(mem_timeout), .cnt_lu(cnt_lu), .cnt_br(cnt_br), .cnt_mw(cnt_mw)
   );

   pipeline_stall_controller #(.TIMEOUT(4), .CNT_W(2)) u_small (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write_s), .if_id_write(if_id_write_s),
      .if_id_flush(if_id_flush_s), .id_ex_bubble(id_ex_bubble_s), .pipe_freeze(pipe_freeze_s),
      .mem_timeout(mem_timeout_s), .cnt_lu(cnt_lu_s), .cnt_br(cnt_br_s), .cnt_mw(cnt_mw_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout}.
   function automatic logic [5:0] exp_ctrl(input bit rst, input bit err, input bit mw,
                                           input bit br, input bit lu);
      if (!rst) return 6'b110000;
      if (err)  return 6'b000011;
      if (mw)   return 6'b000010;
      if (br)   return 6'b111100;
      if (lu)   return 6'b000100;
      return 6'b110000;
   endfunction

   task automatic idle();
      id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 0; ex_mem_read = 0;
      ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic apply_reset();
      rst_n = 0;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      id_rs = 5'd5; ex_rd = 5'd5; ex_mem_read = 1; ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
      #3;
      checks++; if (ctrl !== 6'b110000) begin failures++; $display("FAIL reset_ctrl got=%b exp=110000", ctrl); end
      checks++; if (ctrl_s !== 6'b110000) begin failures++; $display("FAIL reset_ctrl_s got=%b exp=110000", ctrl_s); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({cnt_lu, cnt_br, cnt_mw} !== 48'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", cnt_lu, cnt_br, cnt_mw); end
      checks++; if (ctrl !== 6'b110000) begin failures++; $display("FAIL reset_ctrl_held got=%b exp=110000", ctrl); end
      idle();
      @(negedge clk);
      rst_n = 1;
      #1;
      checks++; if (ctrl !== 6'b110000) begin failures++; $display("FAIL idle_ctrl got=%b exp=110000", ctrl); end
   endtask

   task automatic test_load_use();
      apply_reset();
      @(negedge clk);
      ex_mem_read = 1; ex_rd = 5'd5; id_rs = 5'd5;
      #1;
      checks++; if (ctrl !== 6'b000100) begin failures++; $display("FAIL lu_stall got=%b exp=000100", ctrl); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (ctrl !== 6'b110000) begin failures++; $display("FAIL lu_release got=%b exp=110000", ctrl); end
      checks++; if (cnt_lu !== 16'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", cnt_lu); end
      // rt dependency counts only when the instruction really reads rt.
      @(negedge clk);
      ex_mem_read = 1; ex_rd = 5'd9; id_rs = 5'd2; id_rt = 5'd9; id_uses_rt = 1;
      #1;
      checks++; if (ctrl !== 6'b000100) begin failures++; $display("FAIL lu_rt_stall got=%b exp=000100", ctrl); end
   endtask

   task automatic test_no_false_stall();
      apply_reset();
      @(negedge clk);
      ex_mem_read = 1; ex_rd = 5'd0; id_rs = 5'd0;
      #1;
      checks++; if (ctrl !== 6'b110000) begin failures++; $display("FAIL r0_no_stall got=%b exp=110000", ctrl); end
      @(negedge clk);
      ex_mem_read = 1; ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 0;
      #1;
      checks++; if (ctrl !== 6'b110000) begin failures++; $display("FAIL rt_unused_no_stall got=%b exp=110000", ctrl); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (cnt_lu !== 16'd0) begin failures++; $display("FAIL no_stall_count got=%0d exp=0", cnt_lu); end
   endtask

   task automatic test_branch_override();
      apply_reset();
      @(negedge clk);
      ex_mem_read = 1; ex_rd = 5'd5; id_rs = 5'd5; ex_branch_taken = 1;
      #1;
      checks++; if (ctrl !== 6'b111100) begin failures++; $display("FAIL br_flush got=%b exp=111100", ctrl); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (cnt_br !== 16'd1) begin failures++; $display("FAIL br_count got=%0d exp=1", cnt_br); end
      checks++; if (cnt_lu !== 16'd0) begin failures++; $display("FAIL br_lu_count got=%0d exp=0", cnt_lu); end
   endtask

   task automatic test_mem_wait();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
         #1;
         checks++; if (ctrl !== 6'b000010) begin failures++; $display("FAIL mw_freeze[%0d] got=%b exp=000010", i, ctrl); end
      end
      @(negedge clk);
      mem_req = 1; mem_ready = 1; ex_branch_taken = 0;
      #1;
      checks++; if (ctrl !== 6'b110000) begin failures++; $display("FAIL mw_done got=%b exp=110000", ctrl); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (cnt_mw !== 16'd3) begin failures++; $display("FAIL mw_count got=%0d exp=3", cnt_mw); end
      checks++; if (cnt_br !== 16'd0) begin failures++; $display("FAIL mw_br_ignored got=%0d exp=0", cnt_br); end
   endtask

   task automatic test_timeout();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_req = 1; mem_ready = 0;
         #1;
         checks++; if (ctrl_s !== 6'b000010) begin failures++; $display("FAIL to_wait[%0d] got=%b exp=000010", i, ctrl_s); end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_ready = (i != 0); ex_branch_taken = 1;
         #1;
         checks++; if (ctrl_s !== 6'b000011) begin failures++; $display("FAIL to_error[%0d] got=%b exp=000011", i, ctrl_s); end
      end
      checks++; if (cnt_mw_s !== 2'd3) begin failures++; $display("FAIL to_mw_sat got=%0d exp=3", cnt_mw_s); end
      checks++; if (cnt_br_s !== 2'd0) begin failures++; $display("FAIL to_br_frozen got=%0d exp=0", cnt_br_s); end
      checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL to_big_no_err got=%b exp=0", mem_timeout); end
      rst_n = 0;
      #2;
      checks++; if (ctrl_s !== 6'b110000) begin failures++; $display("FAIL to_in_reset got=%b exp=110000", ctrl_s); end
      checks++; if ({cnt_lu_s, cnt_br_s, cnt_mw_s} !== 6'd0) begin failures++; $display("FAIL to_reset_cnt got=%0d/%0d/%0d exp=0/0/0", cnt_lu_s, cnt_br_s, cnt_mw_s); end
      idle();
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      #1;
      checks++; if (ctrl_s !== 6'b110000) begin failures++; $display("FAIL to_recover got=%b exp=110000", ctrl_s); end
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ex_branch_taken = 1;
      end
      @(negedge clk);
      idle();
      #1;
      checks++; if (cnt_br_s !== 2'd3) begin failures++; $display("FAIL sat_br_small got=%0d exp=3", cnt_br_s); end
      checks++; if (cnt_br !== 16'd5) begin failures++; $display("FAIL sat_br_big got=%0d exp=5", cnt_br); end
   endtask

   // Model per instance: consecutive-wait run length, sticky error, event totals.
   task automatic test_random();
      int  to_lim[2];
      int  cnt_max[2];
      bit  err[2];
      int  run[2], nlu[2], nbr[2], nmw[2];
      bit  mw, lu;
      logic [5:0] obs, exp;
      int  olu, obr, omw;
      to_lim  = '{256, 4};
      cnt_max = '{65535, 3};
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         err[k] = 0; run[k] = 0; nlu[k] = 0; nbr[k] = 0; nmw[k] = 0;
      end
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (n == 200) begin
            rst_n = 0;
            for (int k = 0; k < 2; k++) begin
               err[k] = 0; run[k] = 0; nlu[k] = 0; nbr[k] = 0; nmw[k] = 0;
            end
         end else if (n == 202) begin
            rst_n = 1;
         end
         id_rs = 5'($urandom_range(0, 7));
         id_rt = 5'($urandom_range(0, 7));
         ex_rd = 5'($urandom_range(0, 7));
         id_uses_rt      = 1'($urandom_range(0, 1));
         ex_mem_read     = ($urandom_range(0, 99) < 60);
         ex_branch_taken = ($urandom_range(0, 99) < 20);
         mem_req         = ($urandom_range(0, 99) < 50);
         mem_ready       = ($urandom_range(0, 99) < 40);
         mw = mem_req && !mem_ready;
         lu = ex_mem_read && (ex_rd != 0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
         #1;
         for (int k = 0; k < 2; k++) begin
            exp = exp_ctrl(rst_n, err[k], mw, ex_branch_taken, lu);
            obs = (k == 0) ? ctrl : ctrl_s;
            olu = (k == 0) ? int'(cnt_lu) : int'(cnt_lu_s);
            obr = (k == 0) ? int'(cnt_br) : int'(cnt_br_s);
            omw = (k == 0) ? int'(cnt_mw) : int'(cnt_mw_s);
            checks++; if (obs !== exp) begin failures++; $display("FAIL rand_ctrl[%0d] cyc=%0d got=%b exp=%b", k, n, obs, exp); end
            checks++; if (olu != nlu[k]) begin failures++; $display("FAIL rand_cnt_lu[%0d] cyc=%0d got=%0d exp=%0d", k, n, olu, nlu[k]); end
            checks++; if (obr != nbr[k]) begin failures++; $display("FAIL rand_cnt_br[%0d] cyc=%0d got=%0d exp=%0d", k, n, obr, nbr[k]); end
            checks++; if (omw != nmw[k]) begin failures++; $display("FAIL rand_cnt_mw[%0d] cyc=%0d got=%0d exp=%0d", k, n, omw, nmw[k]); end
         end
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            if (rst_n && !err[k]) begin
               if (mw) begin
                  if (nmw[k] < cnt_max[k]) nmw[k]++;
                  run[k]++;
                  if (run[k] == to_lim[k]) err[k] = 1;
               end else begin
                  run[k] = 0;
                  if (ex_branch_taken) begin
                     if (nbr[k] < cnt_max[k]) nbr[k]++;
                  end else if (lu) begin
                     if (nlu[k] < cnt_max[k]) nlu[k]++;
                  end
               end
            end
         end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_load_use();
      test_no_false_stall();
      test_branch_override();
      test_mem_wait();
      test_timeout();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, the maximum consecutive memory-wait cycles before error (range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 16, the width of each performance counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 id_rs, id_rt  in  5 each  ID-stage source register numbers.
REQ-007 id_uses_rt  in  1  ID instruction reads rt.
REQ-008 ex_rd  in  5  EX-stage destination register.
REQ-009 ex_mem_read  in  1  EX instruction is a load.
REQ-010 ex_branch_taken  in  1  branch resolved taken in EX.
REQ-011 mem_req  in  1  MEM stage has an access outstanding.
REQ-012 mem_ready  in  1  memory completes the access this cycle.
REQ-013 pc_write, if_id_write  out  1 each  PC and IF/ID enables.
REQ-014 if_id_flush, id_ex_bubble  out  1 each  squash IF/ID, insert NOP into ID/EX.
REQ-015 pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-016 mem_timeout  out  1  sticky error flag.
REQ-017 cnt_lu, cnt_br, cnt_mw  out  CNT_W each  load-use stalls, branch flushes, memory-wait cycles.

Function
REQ-018 SHALL implement states RUN, MEM_WAIT and ERROR, registered; all control outputs are combinational from state and current inputs.
REQ-019 Memory wait (mw = mem_req && !mem_ready) SHALL have highest priority: pc_write=0, if_id_write=0, pipe_freeze=1, if_id_flush=0, id_ex_bubble=0.
REQ-020 mem_req && mem_ready in the same cycle SHALL cause no stall and SHALL leave or bypass MEM_WAIT to RUN.
REQ-021 Branch flush (ex_branch_taken, no mw) SHALL assert pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1 and SHALL override load-use.
REQ-022 Load-use (ex_mem_read && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)), no mw, no branch) SHALL assert pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
REQ-023 ex_rd==0 SHALL never trigger a load-use stall.
REQ-024 With no condition active, outputs SHALL be pc_write=1, if_id_write=1, others 0.
REQ-025 Transitions: RUN->MEM_WAIT on mw; MEM_WAIT->RUN on !mw; MEM_WAIT->ERROR when the wait-cycle counter reaches TIMEOUT with mw still asserted; ERROR held until reset.
REQ-026 The wait-cycle counter SHALL clear on entry to RUN and count each cycle in MEM_WAIT with mw.
REQ-027 In ERROR: pc_write=0, if_id_write=0, pipe_freeze=1, mem_timeout=1, regardless of inputs.
REQ-028 cnt_lu SHALL increment once per cycle REQ-022 applies; cnt_br once per REQ-021 cycle; cnt_mw once per mw cycle in RUN or MEM_WAIT.
REQ-029 Counters SHALL saturate at all-ones and SHALL not count in ERROR.

Reset
REQ-030 Reset SHALL force state RUN, wait counter 0, all cnt_* 0, mem_timeout 0.
REQ-031 During reset outputs SHALL be pc_write=1, if_id_write=1, others 0.
REQ-032 Reset asserted mid-MEM_WAIT or in ERROR SHALL return to RUN on the next clock after deassertion with no residual stall.

Structure
REQ-033 State encoding and the default TIMEOUT constant SHALL live in the shared pipeline package.
REQ-034 One sub-module, sat_counter (parameterised width, inc, clear), SHALL be instantiated three times for cnt_*.

Verification
REQ-035 lw to r5 in EX, ID reads rs=5 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; cnt_lu=1.
REQ-036 ex_rd=0, ex_mem_read=1, id_rs=0 -> no stall; ex_rd=7, id_rt=7, id_uses_rt=0 -> no stall.
REQ-037 ex_branch_taken=1 with simultaneous load-use -> if_id_flush=1, id_ex_bubble=1, pc_write=1; cnt_br=1, cnt_lu=0.
REQ-038 mem_req=1, mem_ready low 3 cycles then high -> pipe_freeze=1 for exactly 3 cycles, branch input ignored meanwhile; cnt_mw=3.
REQ-039 TIMEOUT=4, mem_ready held low -> ERROR after 4 wait cycles, mem_timeout=1 sticky; rst_n pulse -> RUN, all counters 0.
REQ-040 CNT_W=2, 5 branch flushes -> cnt_br saturates at 3.
